// File: rtl/fpnew_norm_pipe_pkg.sv
// Shared types for the normalization pipeline:
// rounding modes and the stage-A shift plan.
package fpnew_norm_pipe_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  localparam int unsigned PLAN_AMT_W = 16;
  localparam int unsigned PLAN_EXP_W = 16;

  typedef struct packed {
    logic                         shift_left;
    logic [PLAN_AMT_W-1:0]        shift_amt;
    logic signed [PLAN_EXP_W-1:0] final_exp;
    logic                         is_zero;
  } shift_plan_t;

endpackage

// File: rtl/fpnew_norm_pipe_lzc.sv
// Leading-zero counter; cnt_o is 0 when the input is empty.
module fpnew_norm_lzc #(
  parameter int unsigned WIDTH = 50,
  parameter int unsigned CNT_W =
    (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  always_comb begin
    cnt_o = '0;
    // Scan upward so the highest set bit wins.
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/fpnew_norm_pipe.sv
// Two-stage elastic normalizer: stage A plans the shift,
// stage B applies it and packs {exp, mant} plus round/sticky.
module fpnew_norm_pipe
  import fpnew_norm_pipe_pkg::*;
#(
  parameter int unsigned ExpBits   = 8,
  parameter int unsigned ManBits   = 23,
  parameter int unsigned MantWidth = 50,
  parameter int unsigned TagWidth  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       sign_i,
  input  logic [ExpBits+1:0]         exp_i,
  input  logic [MantWidth-1:0]       mant_i,
  input  logic                       sticky_i,
  input  roundmode_e                 rnd_mode_i,
  input  logic                       eff_sub_i,
  input  logic [TagWidth-1:0]        tag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ExpBits+ManBits-1:0] abs_value_o,
  output logic [1:0]                 round_sticky_o,
  output logic                       sign_o,
  output roundmode_e                 rnd_mode_o,
  output logic                       eff_sub_o,
  output logic [TagWidth-1:0]        tag_o,
  output logic                       of_o,
  output logic                       zero_o
);

  localparam int unsigned LzcW =
    (MantWidth > 1) ? $clog2(MantWidth) : 1;
  localparam int unsigned AbsW = ExpBits + ManBits;
  localparam int unsigned LowW = MantWidth - 2 - ManBits;

  localparam logic signed [PLAN_EXP_W-1:0] OneS =
    PLAN_EXP_W'(1);
  localparam logic signed [PLAN_EXP_W-1:0] MwS =
    PLAN_EXP_W'(MantWidth);
  localparam logic signed [PLAN_EXP_W-1:0] ExpMaxS =
    PLAN_EXP_W'((1 << ExpBits) - 1);

  logic valid_a_q, valid_a_d;
  logic valid_b_q, valid_b_d;
  logic ready_a, ready_b;

  assign ready_b    = !valid_b_q || out_ready_i;
  assign ready_a    = !valid_a_q || ready_b;
  assign in_ready_o = ready_a;

  always_comb begin
    valid_a_d = valid_a_q;
    valid_b_d = valid_b_q;
    if (flush_i) begin
      valid_a_d = 1'b0;
      valid_b_d = 1'b0;
    end else begin
      if (ready_a) valid_a_d = in_valid_i;
      if (ready_b) valid_b_d = valid_a_q;
    end
  end

  // ---------------- stage A: shift plan ----------------
  logic [LzcW-1:0] lz_cnt;
  logic            lz_empty;

  fpnew_norm_lzc #(
    .WIDTH (MantWidth),
    .CNT_W (LzcW)
  ) u_lzc (
    .in_i    (mant_i),
    .cnt_o   (lz_cnt),
    .empty_o (lz_empty)
  );

  logic signed [PLAN_EXP_W-1:0] exp_s;
  logic signed [PLAN_EXP_W-1:0] lz_s;
  logic signed [PLAN_EXP_W-1:0] diff_s;
  logic signed [PLAN_EXP_W-1:0] neg_s;
  shift_plan_t                  plan_d;

  assign exp_s  = PLAN_EXP_W'($signed(exp_i));
  assign lz_s   = $signed(PLAN_EXP_W'(lz_cnt));
  assign diff_s = exp_s - lz_s;
  assign neg_s  = -exp_s;

  always_comb begin
    plan_d = '0;
    if (lz_empty) begin
      plan_d.is_zero    = 1'b1;
      plan_d.shift_left = 1'b1;
    end else if (diff_s >= 0) begin
      plan_d.shift_left = 1'b1;
      plan_d.shift_amt  = PLAN_AMT_W'(lz_cnt);
      plan_d.final_exp  = diff_s + OneS;
    end else if (exp_s >= 0) begin
      plan_d.shift_left = 1'b1;
      plan_d.shift_amt  = PLAN_AMT_W'(exp_s);
    end else if (neg_s > MwS) begin
      plan_d.shift_amt  = PLAN_AMT_W'(MantWidth);
    end else begin
      plan_d.shift_amt  = PLAN_AMT_W'(neg_s);
    end
  end

  shift_plan_t          plan_q;
  logic [MantWidth-1:0] mant_a_q;
  logic                 sticky_a_q;
  logic                 sign_a_q;
  roundmode_e           rnd_a_q;
  logic                 eff_sub_a_q;
  logic [TagWidth-1:0]  tag_a_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_a_q   <= 1'b0;
      plan_q      <= '0;
      mant_a_q    <= '0;
      sticky_a_q  <= 1'b0;
      sign_a_q    <= 1'b0;
      rnd_a_q     <= RNE;
      eff_sub_a_q <= 1'b0;
      tag_a_q     <= '0;
    end else begin
      valid_a_q <= valid_a_d;
      if (ready_a) begin
        plan_q      <= plan_d;
        mant_a_q    <= mant_i;
        sticky_a_q  <= sticky_i;
        sign_a_q    <= sign_i;
        rnd_a_q     <= rnd_mode_i;
        eff_sub_a_q <= eff_sub_i;
        tag_a_q     <= tag_i;
      end
    end
  end

  // ---------------- stage B: shift and pack ----------------
  logic [MantWidth-1:0] m_sh;
  logic [MantWidth-1:0] lost_mask;
  logic                 rs_lost;
  logic [ManBits-1:0]   mant_f;
  logic                 rnd_b;
  logic                 stk_b;
  logic                 of_b;
  logic [AbsW-1:0]      abs_d;
  logic [1:0]           rs_d;

  assign m_sh = plan_q.shift_left
              ? (mant_a_q << plan_q.shift_amt)
              : (mant_a_q >> plan_q.shift_amt);

  // Bits dropped off the bottom by a right shift.
  assign lost_mask =
    ~({MantWidth{1'b1}} << plan_q.shift_amt);
  assign rs_lost = !plan_q.shift_left &&
                   (|(mant_a_q & lost_mask));

  assign mant_f = m_sh[MantWidth-2 -: ManBits];
  assign rnd_b  = m_sh[LowW];
  assign stk_b  = (|m_sh[LowW-1:0]) | sticky_a_q | rs_lost;
  assign of_b   = plan_q.final_exp >= ExpMaxS;

  always_comb begin
    abs_d = {plan_q.final_exp[ExpBits-1:0], mant_f};
    rs_d  = {rnd_b, stk_b};
    if (of_b) begin
      abs_d = {{ExpBits{1'b1}}, {ManBits{1'b0}}};
      rs_d  = 2'b00;
    end
  end

  logic [AbsW-1:0]     abs_q;
  logic [1:0]          rs_q;
  logic                sign_b_q;
  roundmode_e          rnd_b_q;
  logic                eff_sub_b_q;
  logic [TagWidth-1:0] tag_b_q;
  logic                of_q;
  logic                zero_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_b_q   <= 1'b0;
      abs_q       <= '0;
      rs_q        <= '0;
      sign_b_q    <= 1'b0;
      rnd_b_q     <= RNE;
      eff_sub_b_q <= 1'b0;
      tag_b_q     <= '0;
      of_q        <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      valid_b_q <= valid_b_d;
      if (ready_b) begin
        abs_q       <= abs_d;
        rs_q        <= rs_d;
        sign_b_q    <= sign_a_q;
        rnd_b_q     <= rnd_a_q;
        eff_sub_b_q <= eff_sub_a_q;
        tag_b_q     <= tag_a_q;
        of_q        <= of_b;
        zero_q      <= plan_q.is_zero;
      end
    end
  end

  assign out_valid_o    = valid_b_q;
  assign abs_value_o    = abs_q;
  assign round_sticky_o = rs_q;
  assign sign_o         = sign_b_q;
  assign rnd_mode_o     = rnd_b_q;
  assign eff_sub_o      = eff_sub_b_q;
  assign tag_o          = tag_b_q;
  assign of_o           = of_q;
  assign zero_o         = zero_q;

endmodule
